// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read / one-write register file feeding the ALU; optional write forwarding via REG_FILE_WRITE_FORWARD_EN
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] rd1_stored;
  logic [DATA_WIDTH-1:0] rd2_stored;

  // Writes to address 0 are dropped so entry 0 stays at its reset value of zero.
  assign wr_valid = WE3 && (A3 != '0);

  // Storage: async clear of every entry, single write port on the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[A3] <= WD3;
    end
  end

  // Combinational read of stored contents; address 0 is forced to zero regardless of storage.
  always_comb begin
    rd1_stored = (A1 == '0) ? '0 : regs_q[A1];
    rd2_stored = (A2 == '0) ? '0 : regs_q[A2];
  end

`ifdef REG_FILE_WRITE_FORWARD_EN
  // Bypass the in-flight write onto a matching read port; reset and register 0 take priority.
  always_comb begin
    RD1 = (reset_n && wr_valid && (A3 == A1)) ? WD3 : rd1_stored;
    RD2 = (reset_n && wr_valid && (A3 == A2)) ? WD3 : rd2_stored;
  end
`else
  // Reads see stored contents only; no path from the write port to the read data.
  always_comb begin
    RD1 = rd1_stored;
    RD2 = rd2_stored;
  end
`endif

endmodule
